// File: rtl/idct_transpose_buf.sv
`default_nettype none
// ============================================================================
// idct_transpose_buf : ping-pong 4x4 transpose buffer between IDCT passes
// Revision 1.0
// ============================================================================
module idct_transpose_buf #(
   parameter int CLIP_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [24:0] d_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [24:0] d_out_1,
   output logic signed [24:0] d_out_2,
   output logic signed [24:0] d_out_3,
   output logic signed [24:0] d_out_4
);

   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_state_t;

   bank_state_t state_q [2];
   bank_state_t state_d [2];
   logic        wbank_q, wbank_d;
   logic        rbank_q, rbank_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [1:0]  rcnt_q, rcnt_d;
   logic        wr_fire, rd_fire;
   logic signed [24:0] clip_data;

   // Entry index is {row, col}, so a block is stored row-major.
   logic [24:0] mem [2][16];

   generate
      if (CLIP_W < 25) begin : g_clip
         localparam logic signed [24:0] SAT_MAX = 25'((2 ** (CLIP_W - 1)) - 1);
         localparam logic signed [24:0] SAT_MIN = -SAT_MAX - 25'sd1;
         always_comb begin
            if (d_in > SAT_MAX) begin
               clip_data = SAT_MAX;
            end else if (d_in < SAT_MIN) begin
               clip_data = SAT_MIN;
            end else begin
               clip_data = d_in;
            end
         end
      end else begin : g_noclip
         assign clip_data = d_in;
      end
   endgenerate

   assign in_ready  = (state_q[wbank_q] == FREE);
   assign out_valid = (state_q[rbank_q] == FULL);
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q[0] <= FREE;
         state_q[1] <= FREE;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         wcnt_q     <= 4'd0;
         rcnt_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // A write can only target a FREE bank and a read only a FULL one, so the
   // two state updates below never touch the same bank in one cycle.
   always_comb begin
      state_d = state_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      if (wr_fire) begin
         wcnt_d = wcnt_q + 4'd1;
         if (wcnt_q == 4'd15) begin
            state_d[wbank_q] = FULL;
            wbank_d          = ~wbank_q;
         end
      end
      if (rd_fire) begin
         rcnt_d = rcnt_q + 2'd1;
         if (rcnt_q == 2'd3) begin
            state_d[rbank_q] = FREE;
            rbank_d          = ~rbank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_fire) begin
         mem[wbank_q][wcnt_q] <= clip_data;
      end
   end

   always_comb begin
      d_out_1 = '0;
      d_out_2 = '0;
      d_out_3 = '0;
      d_out_4 = '0;
      if (out_valid) begin
         d_out_1 = mem[rbank_q][{2'd0, rcnt_q}];
         d_out_2 = mem[rbank_q][{2'd1, rcnt_q}];
         d_out_3 = mem[rbank_q][{2'd2, rcnt_q}];
         d_out_4 = mem[rbank_q][{2'd3, rcnt_q}];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_idct_transpose_buf.sv
`default_nettype none
// ============================================================================
// tb_idct_transpose_buf : randomized and directed checks against a block model
// Revision 1.0
// ============================================================================
module tb_idct_transpose_buf;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               out_ready;
   logic signed [24:0] d_in;
   logic               in_ready, out_valid;
   logic signed [24:0] d_out_1, d_out_2, d_out_3, d_out_4;
   logic               in_ready25, out_valid25;
   logic signed [24:0] d25_1, d25_2, d25_3, d25_4;

   int checks = 0;
   int errors = 0;

   idct_transpose_buf #(.CLIP_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
      .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
   );

   idct_transpose_buf #(.CLIP_W(25)) dut25 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready25),
      .d_in(d_in), .out_valid(out_valid25), .out_ready(out_ready),
      .d_out_1(d25_1), .d_out_2(d25_2), .d_out_3(d25_3), .d_out_4(d25_4)
   );

   always #5 clk = ~clk;

   // Reference model: completed blocks waiting to be drained, plus the block
   // currently being collected. At most two complete blocks can be held.
   typedef int blk_t [16];
   blk_t blocks [$];
   int   part [$];
   int   col = 0;

   function automatic int clip16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [101:0] model_obs();
      logic [24:0] d [4];
      logic ir, ov;
      ir = (blocks.size() < 2);
      ov = (blocks.size() > 0);
      for (int k = 0; k < 4; k++) begin
         d[k] = ov ? 25'(blocks[0][k*4 + col]) : 25'd0;
      end
      return {ir, ov, d[0], d[1], d[2], d[3]};
   endfunction

   function automatic logic [101:0] dut_obs();
      return {in_ready, out_valid, d_out_1, d_out_2, d_out_3, d_out_4};
   endfunction

   task automatic model_reset();
      blocks.delete();
      part.delete();
      col = 0;
   endtask

   task automatic model_step(input logic iv, input int din, input logic ordy);
      bit wf, rf;
      blk_t b;
      wf = iv && (blocks.size() < 2);
      rf = ordy && (blocks.size() > 0);
      if (rf) begin
         col++;
         if (col == 4) begin
            blocks.delete(0);
            col = 0;
         end
      end
      if (wf) begin
         part.push_back(clip16(din));
         if (part.size() == 16) begin
            for (int i = 0; i < 16; i++) b[i] = part[i];
            blocks.push_back(b);
            part.delete();
         end
      end
   endtask

   task automatic cycle(input logic iv, input int din, input logic ordy);
      in_valid  = iv;
      d_in      = 25'(din);
      out_ready = ordy;
      @(posedge clk);
      if (!reset) model_reset();
      else model_step(iv, din, ordy);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      cycle(1'b0, 0, 1'b0);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cycle(1'b1, 5, 1'b1);
      cycle(1'b1, 5, 1'b1);
      reset = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if ({d_out_1, d_out_2, d_out_3, d_out_4} !== 100'd0) begin
         errors++; $display("FAIL reset_d_out: got %0d %0d %0d %0d expected 0 0 0 0",
                            d_out_1, d_out_2, d_out_3, d_out_4);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL stream_model: got %h expected %h", dut_obs(), model_obs());
         end
         cycle(1'b1, i, 1'b1);
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (out_valid !== 1'b1 || d_out_1 !== 25'(c) || d_out_2 !== 25'(c + 4) ||
             d_out_3 !== 25'(c + 8) || d_out_4 !== 25'(c + 12)) begin
            errors++;
            $display("FAIL stream_col%0d: got v=%b %0d %0d %0d %0d expected v=1 %0d %0d %0d %0d",
                     c, out_valid, d_out_1, d_out_2, d_out_3, d_out_4, c, c + 4, c + 8, c + 12);
         end
         cycle(1'b0, 0, 1'b1);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_clip();
      int vals [4];
      int exp16 [4];
      vals  = '{-40000, 40000, -32768, 32767};
      exp16 = '{-32768, 32767, -32768, 32767};
      apply_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, (i < 4) ? vals[i] : 0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (out_valid !== 1'b1 || d_out_1 !== 25'(exp16[c])) begin
            errors++; $display("FAIL clip16_col%0d: got v=%b %0d expected v=1 %0d",
                               c, out_valid, d_out_1, exp16[c]);
         end
         checks++;
         if (out_valid25 !== 1'b1 || d25_1 !== 25'(vals[c])) begin
            errors++; $display("FAIL clip25_col%0d: got v=%b %0d expected v=1 %0d",
                               c, out_valid25, d25_1, vals[c]);
         end
         cycle(1'b0, 0, 1'b1);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_fill%0d: got in_ready %b expected 1", i, in_ready);
         end
         cycle(1'b1, i, 1'b0);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_full: got in_ready %b out_valid %b expected 0 1",
                            in_ready, out_valid);
      end
      cycle(1'b1, 32, 1'b0);
      checks++;
      if (dut_obs() !== model_obs()) begin
         errors++; $display("FAIL bp_refuse: got %h expected %h", dut_obs(), model_obs());
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (in_ready !== 1'b0 || d_out_1 !== 25'(c) || d_out_2 !== 25'(c + 4) ||
             d_out_3 !== 25'(c + 8) || d_out_4 !== 25'(c + 12)) begin
            errors++;
            $display("FAIL bp_col%0d: got rdy=%b %0d %0d %0d %0d expected rdy=0 %0d %0d %0d %0d",
                     c, in_ready, d_out_1, d_out_2, d_out_3, d_out_4, c, c + 4, c + 8, c + 12);
         end
         cycle(1'b0, 0, 1'b1);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || d_out_1 !== 25'd16 || d_out_4 !== 25'd28) begin
         errors++; $display("FAIL bp_release: got rdy=%b v=%b %0d %0d expected rdy=1 v=1 16 28",
                            in_ready, out_valid, d_out_1, d_out_4);
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL bp_drain: got %h expected %h", dut_obs(), model_obs());
         end
         cycle(1'b0, 0, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      int ncol = 0;
      int b, c;
      apply_reset();
      for (int i = 0; i < 56; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready);
         end
         checks++;
         if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL b2b_model: got %h expected %h", dut_obs(), model_obs());
         end
         if (out_valid === 1'b1) begin
            b = ncol / 4;
            c = ncol % 4;
            checks++;
            if (d_out_1 !== 25'(16*b + c) || d_out_2 !== 25'(16*b + c + 4) ||
                d_out_3 !== 25'(16*b + c + 8) || d_out_4 !== 25'(16*b + c + 12)) begin
               errors++;
               $display("FAIL b2b_blk%0d_col%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                        b, c, d_out_1, d_out_2, d_out_3, d_out_4,
                        16*b + c, 16*b + c + 4, 16*b + c + 8, 16*b + c + 12);
            end
            ncol++;
         end
         cycle(i < 48, i, 1'b1);
      end
      checks++;
      if (ncol != 12) begin
         errors++; $display("FAIL b2b_count: got %0d columns expected 12", ncol);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 7; i++) cycle(1'b1, i, 1'b1);
      reset = 1'b0;
      cycle(1'b1, 99, 1'b1);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_valid%0d: got %b expected 0", i, out_valid);
         end
         cycle(1'b1, 100 + i, 1'b1);
      end
      checks++;
      if (out_valid !== 1'b1 || d_out_1 !== 25'd100 || d_out_2 !== 25'd104 ||
          d_out_3 !== 25'd108 || d_out_4 !== 25'd112) begin
         errors++; $display("FAIL rmid_col0: got v=%b %0d %0d %0d %0d expected v=1 100 104 108 112",
                            out_valid, d_out_1, d_out_2, d_out_3, d_out_4);
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL rmid_drain: got %h expected %h", dut_obs(), model_obs());
         end
         cycle(1'b0, 0, 1'b1);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b0);
      cycle(1'b0, 0, 1'b1);
      cycle(1'b0, 0, 1'b1);
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (out_valid !== 1'b1 || d_out_1 !== 25'd2 || d_out_2 !== 25'd6 ||
             d_out_3 !== 25'd10 || d_out_4 !== 25'd14) begin
            errors++; $display("FAIL stall_hold%0d: got v=%b %0d %0d %0d %0d expected v=1 2 6 10 14",
                               s, out_valid, d_out_1, d_out_2, d_out_3, d_out_4);
         end
         cycle(1'b0, 0, (s == 5));
      end
      checks++;
      if (out_valid !== 1'b1 || d_out_1 !== 25'd3 || d_out_2 !== 25'd7 ||
          d_out_3 !== 25'd11 || d_out_4 !== 25'd15) begin
         errors++; $display("FAIL stall_col3: got v=%b %0d %0d %0d %0d expected v=1 3 7 11 15",
                            out_valid, d_out_1, d_out_2, d_out_3, d_out_4);
      end
      cycle(1'b0, 0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stall_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic signed [24:0] r;
      int din;
      logic iv, ordy;
      apply_reset();
      for (int n = 0; n < 800; n++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: din = 32767 + int'($urandom_range(0, 2)) - 1;
            1: din = -32768 + int'($urandom_range(0, 2)) - 1;
            default: begin
               r   = 25'($urandom);
               din = int'(r);
            end
         endcase
         checks++;
         if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL random_model%0d: got %h expected %h", n, dut_obs(), model_obs());
         end
         reset = ($urandom_range(0, 199) != 0);
         cycle(iv, din, ordy);
         reset = 1'b1;
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d_in      = '0;
      test_reset();
      test_stream();
      test_clip();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
